// File: rtl/serial_adder_pkg.sv
// Shared types for the serial chunk adder: FSM state encoding and index sizing.
package serial_adder_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Chunk index width; a single-step adder still needs one bit.
  function automatic int unsigned idx_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder with carry in/out.
module chunk_adder #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder summing CHUNK bits per clock, LSB chunk first.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b via a + ~b + 1).
module serial_chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned STEPS = WIDTH / CHUNK;
  localparam int unsigned IdxW  = idx_width(STEPS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(STEPS - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IdxW-1:0]  idx_q;
  logic             cin_q;

  logic [WIDTH-1:0] b_eff;
  logic             cin_init;
  logic             accept;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff    = sub ? ~b : b;
  assign cin_init = sub;
`else
  assign b_eff    = b;
  assign cin_init = 1'b0;
`endif

  // Starts arriving mid-operation are dropped; DONE accepts for back-to-back runs.
  assign accept = start && (state_q != StAdd);

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x    (a_q[idx_q*CHUNK +: CHUNK]),
    .y    (b_q[idx_q*CHUNK +: CHUNK]),
    .cin  (cin_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else if (accept) begin
      state_q <= StAdd;
      a_q     <= a;
      b_q     <= b_eff;
      idx_q   <= '0;
      cin_q   <= cin_init;
      sum     <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
        end
        StAdd: begin
          sum[idx_q*CHUNK +: CHUNK] <= chunk_s;
          cin_q                     <= chunk_cout;
          if (idx_q == LastIdx) begin
            carry   <= chunk_cout;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder: CHUNK=2 main instance plus CHUNK=8 and CHUNK=1.
module tb_serial_chunk_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q8[$];
  exp_t q1[$];

  logic       st0 = 1'b0, st8 = 1'b0, st1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a8 = '0, b8 = '0, a1 = '0, b1 = '0;
  logic       sub0 = 1'b0;
  logic       busy0, done0, carry0, busy8, done8, carry8, busy1, done1, carry1;
  logic [7:0] sum0, sum8, sum1;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub0),
`endif
    .busy(busy0), .done(done0), .sum(sum0), .carry(carry0)
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; the expected result is queued with its done cycle.
  task automatic issue(input int id, input logic [7:0] av, input logic [7:0] bv, input logic sb,
                       input logic [7:0] es, input logic ec);
    exp_t e;
    e.s = es;
    e.c = ec;
    case (id)
      0: begin
        st0 = 1'b1; a0 = av; b0 = bv; sub0 = sb;
        e.cyc = cyc + 1 + 4;
        q0.push_back(e);
      end
      8: begin
        st8 = 1'b1; a8 = av; b8 = bv;
        e.cyc = cyc + 1 + 1;
        q8.push_back(e);
      end
      default: begin
        st1 = 1'b1; a1 = av; b1 = bv;
        e.cyc = cyc + 1 + 8;
        q1.push_back(e);
      end
    endcase
    tick();
    st0 = 1'b0;
    st8 = 1'b0;
    st1 = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_done_c2", 1, 0);
      else begin
        e = q0.pop_front();
        chk("sum_c2", {24'd0, sum0}, {24'd0, e.s});
        chk("carry_c2", {31'd0, carry0}, {31'd0, e.c});
        chk("done_cycle_c2", cyc, e.cyc);
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_done_c8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("sum_c8", {24'd0, sum8}, {24'd0, e.s});
        chk("carry_c8", {31'd0, carry8}, {31'd0, e.c});
        chk("done_cycle_c8", cyc, e.cyc);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_done_c1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("sum_c1", {24'd0, sum1}, {24'd0, e.s});
        chk("carry_c1", {31'd0, carry1}, {31'd0, e.c});
        chk("done_cycle_c1", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_busy", {31'd0, busy0}, 0);
    chk("reset_done", {31'd0, done0}, 0);
    chk("reset_sum", {24'd0, sum0}, 0);
    chk("reset_carry", {31'd0, carry0}, 0);
    rst_n = 1'b1;
    tick();

    // 1: zero operands, busy for exactly four cycles
    issue(0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    chk("busy_t0", {31'd0, busy0}, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("busy_mid", {31'd0, busy0}, 1);
    end
    tick();
    chk("busy_end", {31'd0, busy0}, 0);
    tick();
    chk("done_single", {31'd0, done0}, 0);
    tick();

    // 2: simple add and full ripple
    issue(0, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0);
    repeat (6) tick();
    issue(0, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1);
    repeat (6) tick();

    // 3: start while busy is ignored
    issue(0, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
    tick();
    st0 = 1'b1; a0 = 8'd1; b0 = 8'd1;
    tick();
    st0 = 1'b0;
    repeat (6) tick();
    chk("held_sum", {24'd0, sum0}, 44);

    // 4: async reset mid-operation
    issue(0, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    void'(q0.pop_back());
    chk("abort_busy", {31'd0, busy0}, 0);
    chk("abort_done", {31'd0, done0}, 0);
    chk("abort_sum", {24'd0, sum0}, 0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    issue(0, 8'd17, 8'd25, 1'b0, 8'd42, 1'b0);
    repeat (6) tick();

    // 5: back-to-back with start held through DONE
    begin
      exp_t e;
      st0 = 1'b1; a0 = 8'd3; b0 = 8'd4;
      e.s = 8'd7; e.c = 1'b0; e.cyc = cyc + 5;
      q0.push_back(e);
      e.s = 8'd4; e.c = 1'b1; e.cyc = cyc + 10;
      q0.push_back(e);
      tick();
      a0 = 8'd250; b0 = 8'd10;
      repeat (5) tick();
      st0 = 1'b0;
      repeat (6) tick();
    end

`ifdef SERIAL_ADDER_SUB_EN
    // 6: subtraction
    issue(0, 8'd100, 8'd37, 1'b1, 8'd63, 1'b1);
    repeat (6) tick();
    issue(0, 8'd5, 8'd7, 1'b1, 8'd254, 1'b0);
    repeat (6) tick();
    sub0 = 1'b0;
`endif

    // Other chunk widths: full-width single step and bit-serial
    issue(8, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
    repeat (3) tick();
    issue(1, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1);
    repeat (10) tick();
    issue(1, 8'd90, 8'd60, 1'b0, 8'd150, 1'b0);
    repeat (10) tick();

    chk("pending_c2", q0.size(), 0);
    chk("pending_c8", q8.size(), 0);
    chk("pending_c1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
